// File: rtl/iob_ram_sp_pkg.sv
// Shared types and latency constants for the single-port RAM requester.
package iob_ram_sp_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam int RAM_RD_LAT = 1;
    localparam int RSP_LAT    = 2;

endpackage

// File: rtl/iob_ram_sp_rsp_fifo.sv
// Register-based response FIFO; holds read data until the consumer takes it.
module iob_ram_sp_rsp_fifo
    import iob_ram_sp_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [DATA_W-1:0]              din,
    input  logic                           pop,
    output logic [DATA_W-1:0]              dout,
    output logic [$clog2(RSP_DEPTH):0]     count,
    output logic                           empty,
    output logic                           full
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && full));
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(RSP_DEPTH));

endmodule

// File: rtl/iob_ram_sp_requester.sv
// Single-port RAM initiator: request stream to RAM strobes, credit-limited read response stream.
module iob_ram_sp_requester
    import iob_ram_sp_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 14,
    parameter int RSP_DEPTH      = 2,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    output logic              init_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] clr_addr;
    logic              inflight;
    logic              rd_fire;
    logic              pop;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     credit_used;
    logic              fifo_empty;
    logic              fifo_full;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) state <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_addr == '1) state_next = S_RUN;
    end

    // Outputs are forced idle while reset is held, independent of the stored state
    always_comb begin
        init_done = 1'b0;
        req_ready = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        rd_fire   = 1'b0;
        if (ap_rst_n) begin
            case (state)
                S_CLEAR: begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = clr_addr;
                end
                S_RUN: begin
                    init_done = 1'b1;
                    req_ready = (credit_used < CW'(RSP_DEPTH));
                    ram_en    = req_valid && req_ready;
                    ram_we    = req_we;
                    ram_addr  = req_addr;
                    ram_din   = req_wdata;
                    rd_fire   = req_valid && req_ready && !req_we;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            clr_addr <= '0;
        end else if (state == S_CLEAR && clr_addr != '1) begin
            clr_addr <= clr_addr + 1'b1;
        end
    end

    // Stage boundary: read strobe -> RAM dout valid, captured into the FIFO next cycle
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) inflight <= 1'b0;
        else           inflight <= rd_fire;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst_n) assert (!(inflight && fifo_full));
    end

    // A read holds its credit from acceptance until the consumer pops it
    assign credit_used = fifo_count + CW'(inflight);
    assign rsp_valid   = ap_rst_n && !fifo_empty;
    assign pop         = rsp_valid && rsp_ready;

    iob_ram_sp_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .push  (inflight),
        .din   (ram_dout),
        .pop   (pop),
        .dout  (rsp_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_iob_ram_sp_requester.sv
// Scoreboard bench for iob_ram_sp_requester with a behavioural 1-cycle-latency RAM.
module tb_iob_ram_sp_requester;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int RSP_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              init_done;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    always #5 clk = ~clk;

    iob_ram_sp_requester #(
        .DATA_W         (DATA_W),
        .ADDR_W         (ADDR_W),
        .RSP_DEPTH      (RSP_DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .init_done (init_done),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    logic [DATA_W-1:0] ram_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) ram_mem[i] = 8'hEE;
        ram_dout = 8'hEE;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] shadow [16];
    bit rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every handshaken response is matched against the oldest expected entry
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got rdata %0h, expected no response at %0t", rsp_rdata, $time);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        output bit acc);
        int cyc;
        acc = 1'b0;
        cyc = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!acc && cyc < 64) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                check("acc_ram_en", ram_en, 1);
                check("acc_ram_we", ram_we, we);
                check("acc_ram_addr", ram_addr, a);
                if (we) shadow[a] = d;
                else    exp_q.push_back(shadow[a]);
            end
            tick();
            cyc++;
        end
        req_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL req_timeout: got no req_ready in 64 cycles, expected acceptance at %0t", $time);
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("clr_ram_en", ram_en, 1);
            check("clr_ram_we", ram_we, 1);
            check("clr_ram_addr", ram_addr, k);
            check("clr_ram_din", ram_din, 0);
            check("clr_req_ready", req_ready, 0);
            check("clr_init_done", init_done, 0);
            tick();
        end
        @(negedge clk);
        check("run_init_done", init_done, 1);
        check("run_req_ready", req_ready, 1);
        check("run_rsp_valid", rsp_valid, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        bit acc;
        int cyc;

        rsp_ready = 1'b1;
        do_reset();

        // Clear sweep must have zeroed RAM that started at 0xEE
        send(1'b0, 4'd5, 8'h00, acc);
        send(1'b0, 4'd15, 8'h00, acc);
        repeat (4) tick();

        // Write then immediate read of the same address
        send(1'b1, 4'd3, 8'hA5, acc);
        send(1'b0, 4'd3, 8'h00, acc);
        @(negedge clk);
        check("rd_lat_early", rsp_valid, 0);
        tick();
        @(negedge clk);
        check("rd_lat_valid", rsp_valid, 1);
        check("rd_lat_data", rsp_rdata, 8'hA5);
        tick();
        repeat (3) tick();

        // Backpressure: only RSP_DEPTH reads accepted while the consumer stalls
        send(1'b1, 4'd1, 8'h11, acc);
        send(1'b1, 4'd2, 8'h22, acc);
        send(1'b1, 4'd3, 8'h33, acc);
        repeat (2) tick();
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 8'h00, acc);
        send(1'b0, 4'd2, 8'h00, acc);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        @(negedge clk);
        check("bp_head_valid", rsp_valid, 1);
        check("bp_head_data", rsp_rdata, 8'h11);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("credit_same_cycle", req_ready, 0);
        tick();
        @(negedge clk);
        check("credit_next_cycle", req_ready, 1);
        check("credit_rsp_data", rsp_rdata, 8'h22);
        if (req_ready) exp_q.push_back(8'h33);
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("bp_drained", exp_q.size(), 0);

        // Reset one cycle after a read is accepted: the response must vanish
        send(1'b0, 4'd7, 8'h00, acc);
        do_reset();
        repeat (3) tick();
        @(negedge clk);
        check("post_rst_rsp_valid", rsp_valid, 0);
        tick();

        // Randomised traffic against the shadow memory model
        rand_ready = 1'b1;
        fork
            begin
                while (rand_ready) begin
                    tick();
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join_none
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 4) == 0) tick();
            send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc);
        end
        rand_ready = 1'b0;
        repeat (2) tick();
        rsp_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("final_drain", exp_q.size(), 0);
        tick();
        @(negedge clk);
        check("final_rsp_valid", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
